// File: rtl/touch_adc_pkg.sv
// touch_adc_pkg: shared states, control-byte field positions and result widths for the touch ADC responder
package touch_adc_pkg;
    typedef enum logic [1:0] {IDLE, CMD, BUSY, DATA} state_t;
    localparam int S_BIT    = 7;
    localparam int A_HI     = 6;
    localparam int A_LO     = 4;
    localparam int MODE_BIT = 3;
    localparam int SER_BIT  = 2;
    localparam int PD_HI    = 1;
    localparam int PD_LO    = 0;
    localparam int RES_W12  = 12;
    localparam int RES_W8   = 8;
endpackage

// File: rtl/touch_adc_sync_edge.sv
// touch_adc_sync_edge: multi-stage synchronizer for W lines; bit 0 also gets rise/fall pulses, the others are plain levels
module touch_adc_sync_edge #(
    parameter int             STAGES = 2,
    parameter int             W      = 3,
    parameter logic [W-1:0]   INIT   = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:1] q,
    output logic         rise,
    output logic         fall
);
    logic [STAGES-1:0][W-1:0] sync;
    logic                     prev;

    // shift the raw pins through the synchronizer chain and remember the previous bit-0 sample
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= {STAGES{INIT}};
            prev <= INIT[0];
        end else begin
            sync <= {sync[STAGES-2:0], d};
            prev <= sync[STAGES-1][0];
        end
    end

    assign q    = sync[STAGES-1][W-1:1];
    assign rise = sync[STAGES-1][0] & ~prev;
    assign fall = ~sync[STAGES-1][0] & prev;
endmodule

// File: rtl/touch_adc_responder.sv
// touch_adc_responder: device-side model of an ADS7843-style touch ADC serial port returning injected X/Y values
module touch_adc_responder
    import touch_adc_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [2:0] CH_X        = 3'b101,
    parameter logic [2:0] CH_Y        = 3'b001
) (
    input  logic        clk_clk,
    input  logic        reset_reset_n,
    input  logic        cs_n,
    input  logic        dclk,
    input  logic        din,
    output logic        dout,
    output logic        busy,
    output logic        pen_intr_n,
    input  logic [11:0] x_value,
    input  logic [11:0] y_value,
    input  logic        pen_down
);
    state_t      state, state_n;
    logic [3:0]  cnt, cnt_n;
    logic [5:0]  ctrl, ctrl_n;
    logic [11:0] res, res_n, val;
    logic        dout_n, busy_n, pen_en, pen_en_n;
    logic [2:1]  sq;
    logic        cs_q, din_q, rise, fall;

    touch_adc_sync_edge #(.STAGES(SYNC_STAGES), .W(3), .INIT(3'b100)) u_sync (
        .clk   (clk_clk),
        .rst_n (reset_reset_n),
        .d     ({cs_n, din, dclk}),
        .q     (sq),
        .rise  (rise),
        .fall  (fall)
    );

    assign cs_q  = sq[2];
    assign din_q = sq[1];
    // ctrl holds command bits 6..1 (start bit dropped); the 8th bit arrives live on din_q
    assign val   = ctrl[A_HI-1:A_LO-1] == CH_X ? x_value :
                   ctrl[A_HI-1:A_LO-1] == CH_Y ? y_value : 12'h000;

    // state and output registers; pen interrupt is registered from the current state
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            ctrl       <= '0;
            res        <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            pen_en     <= 1'b1;
            pen_intr_n <= 1'b1;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            ctrl       <= ctrl_n;
            res        <= res_n;
            dout       <= dout_n;
            busy       <= busy_n;
            pen_en     <= pen_en_n;
            pen_intr_n <= ~(pen_down & pen_en & (state == IDLE) & ~busy);
        end
    end

    // command capture on dclk rises, busy/data presentation on dclk falls; deselect overrides everything
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        ctrl_n   = ctrl;
        res_n    = res;
        dout_n   = dout;
        busy_n   = busy;
        pen_en_n = pen_en;
        if (cs_q) begin
            state_n = IDLE;
            cnt_n   = '0;
            dout_n  = 1'b0;
            busy_n  = 1'b0;
        end else if (rise && din_q && (state == IDLE || (state == DATA && cnt == 4'd0))) begin
            state_n = CMD;
            cnt_n   = 4'd1;
            ctrl_n  = '0;
        end else if (rise && state == CMD) begin
            ctrl_n = {ctrl[4:0], din_q};
            cnt_n  = cnt + 4'd1;
            if (cnt == 4'd7) begin
                state_n  = BUSY;
                res_n    = ctrl[MODE_BIT-1] ? {val[11:4], 4'h0} : val;
                cnt_n    = ctrl[MODE_BIT-1] ? 4'(RES_W8 - 1) : 4'(RES_W12 - 1);
                pen_en_n = ~din_q;
            end
        end else if (fall) begin
            if (state == BUSY && !busy) begin
                busy_n = 1'b1;
            end else if (state == BUSY || (state == DATA && cnt != 4'd0)) begin
                state_n = DATA;
                busy_n  = 1'b0;
                dout_n  = res[11];
                res_n   = {res[10:0], 1'b0};
                cnt_n   = state == DATA ? cnt - 4'd1 : cnt;
            end else begin
                dout_n  = 1'b0;
                state_n = state == DATA ? IDLE : state;
            end
        end
    end
endmodule

// File: tb/tb_touch_adc_responder.sv
// tb_touch_adc_responder: drives host-style bit-banged conversions and checks dout/busy/pen_intr_n against a per-dclk scoreboard
module tb_touch_adc_responder;
    logic        clk_clk = 1'b0;
    logic        reset_reset_n, cs_n, dclk, din, pen_down;
    logic [11:0] x_value, y_value;
    logic        dout, busy, pen_intr_n;

    int   n_chk  = 0;
    int   n_fail = 0;
    logic din_a [64];
    logic ed    [64];
    logic eb    [64];
    logic ep    [64];
    logic pen_en = 1'b1;

    touch_adc_responder dut (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .cs_n          (cs_n),
        .dclk          (dclk),
        .din           (din),
        .dout          (dout),
        .busy          (busy),
        .pen_intr_n    (pen_intr_n),
        .x_value       (x_value),
        .y_value       (y_value),
        .pen_down      (pen_down)
    );

    always #5 clk_clk = ~clk_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_plan();
        for (int k = 0; k < 64; k++) begin
            din_a[k] = 1'b0;
            ed[k]    = 1'b0;
            eb[k]    = 1'b0;
            ep[k]    = ~(pen_down & pen_en);
        end
    endtask

    // reference: a command whose start bit is sampled at rise s shows busy before rise s+8,
    // the word MSB-first before rises s+9.., and the pen line is masked until back in IDLE
    task automatic add_cmd(input int s, input logic [7:0] cmd, input logic [11:0] xv, input logic [11:0] yv);
        logic [11:0] v;
        int          w;
        v = cmd[6:4] == 3'b101 ? xv : cmd[6:4] == 3'b001 ? yv : 12'h000;
        w = cmd[3] ? 8 : 12;
        if (cmd[3]) v = v >> 4;
        for (int i = 0; i < 8; i++) din_a[s+i] = cmd[7-i];
        eb[s+8] = 1'b1;
        for (int i = 0; i < w; i++) ed[s+9+i] = v[w-1-i];
        pen_en = ~cmd[0];
        for (int k = s + 1; k < 64; k++) ep[k] = (k <= s + 8 + w) ? 1'b1 : ~(pen_down & pen_en);
    endtask

    // one dclk period = 16 clk: din set at the fall, outputs sampled just before the rise
    task automatic run(input int n, input int chg_at, input logic [11:0] chg_x);
        for (int k = 1; k <= n; k++) begin
            din = din_a[k];
            if (k == chg_at) x_value = chg_x;
            #70;
            chk($sformatf("dout c%0d", k), dout, ed[k]);
            chk($sformatf("busy c%0d", k), busy, eb[k]);
            chk($sformatf("pen c%0d", k), pen_intr_n, ep[k]);
            #10 dclk = 1'b1;
            #80 dclk = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] r;
        logic [7:0]  cmd;
        logic [11:0] nx;
        reset_reset_n = 1'b0;
        cs_n = 1'b1; dclk = 1'b0; din = 1'b0; pen_down = 1'b1;
        x_value = 12'h000; y_value = 12'h000;
        #30;
        chk("reset dout", dout, 1'b0);
        chk("reset busy", busy, 1'b0);
        chk("reset pen", pen_intr_n, 1'b1);
        reset_reset_n = 1'b1;
        #40;
        chk("pen after reset", pen_intr_n, 1'b0);
        cs_n = 1'b0;
        #40;
        // X, 12-bit
        x_value = 12'hA5C;
        clear_plan(); add_cmd(1, 8'hD0, x_value, y_value); run(22, 0, 12'h0);
        // Y, 8-bit
        y_value = 12'h3F1;
        clear_plan(); add_cmd(1, 8'h98, x_value, y_value); run(18, 0, 12'h0);
        // PD0=1 masks the pen interrupt, PD0=0 re-enables it
        clear_plan(); add_cmd(1, 8'h91, x_value, y_value); run(22, 0, 12'h0);
        clear_plan(); add_cmd(1, 8'h90, x_value, y_value); run(22, 0, 12'h0);
        // deselect after the 4th data bit
        x_value = 12'hF0F;
        clear_plan(); add_cmd(1, 8'hD0, x_value, y_value); run(12, 0, 12'h0);
        cs_n = 1'b1;
        #40;
        chk("abort dout", dout, 1'b0);
        chk("abort busy", busy, 1'b0);
        chk("abort pen", pen_intr_n, 1'b0);
        cs_n = 1'b0;
        #40;
        x_value = 12'($urandom_range(4095));
        clear_plan(); add_cmd(1, 8'hD0, x_value, y_value); run(22, 0, 12'h0);
        // leading zeros, overlapped second start bit, x changed mid-DATA
        x_value = 12'($urandom_range(4095));
        y_value = 12'($urandom_range(4095));
        nx = 12'($urandom_range(4095));
        clear_plan();
        add_cmd(4, 8'hD0, x_value, y_value);
        add_cmd(24, 8'hD0, nx, y_value);
        run(45, 18, nx);
        // random commands, including unmapped channel codes
        for (int t = 0; t < 6; t++) begin
            r = $urandom;
            cmd = {1'b1, r[6:0]};
            pen_down = r[8];
            x_value = 12'($urandom_range(4095));
            y_value = 12'($urandom_range(4095));
            #10;
            clear_plan(); add_cmd(1, cmd, x_value, y_value); run(cmd[3] ? 18 : 22, 0, 12'h0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/touch_adc_responder.md
Name: touch_adc_responder

Overview:
- Synthesizable device-side model of the 4-wire resistive touch ADC serial interface (ADS7843-style).
- Responds to the touch_ctrl (cs_n, dclk, din) and drives touch_msg (dout, busy) and the pen interrupt.
- Used in on-board loopback and simulation in place of the panel ADC, so that the host bit-banging driver runs unmodified against injected X/Y coordinates.
- Oversamples the serial lines in the system clock domain.

Parameters:
- SYNC_STAGES, 2, synchronizer depth on cs_n/dclk/din (minimum 2).
- CH_X, 3'b101, A2..A0 code selecting the X coordinate.
- CH_Y, 3'b001, A2..A0 code selecting the Y coordinate.

Ports:
- clk_clk  in  1  system clock; must be at least 8x the dclk frequency.
- reset_reset_n  in  1  asynchronous active-low reset.
- cs_n  in  1  chip select from host (touch_ctrl bit).
- dclk  in  1  serial clock from host.
- din  in  1  serial command data from host.
- dout  out  1  serial conversion result to host (touch_msg bit).
- busy  out  1  conversion busy to host (touch_msg bit).
- pen_intr_n  out  1  pen interrupt, active low.
- x_value  in  12  injected X coordinate.
- y_value  in  12  injected Y coordinate.
- pen_down  in  1  injected pen contact.

Behaviour:
- Interface decision, fixed: one clock, clk_clk; reset_reset_n is asynchronous and active-low.
- Reset values: dout=0, busy=0, pen_intr_n=1, state IDLE, shift registers 0, penirq_en=1.
- Input conditioning:
  - cs_n, dclk and din each pass through SYNC_STAGES flops.
  - A dclk rise/fall event is a one-cycle pulse from comparing the last two synchronized samples.
  - Pin-to-event latency is SYNC_STAGES+1 clk_clk cycles.
  - din is taken from the same synchronized sample as the rising event.
- States:
  - IDLE: on a dclk rise with cs_n=0 and din=1 (start bit), go to CMD with bit count 1. Rises with din=0 are ignored as leading zeros.
  - CMD: shift din on each rise, MSB first, into ctrl[7:0] = S, A2, A1, A0, MODE, SER/DFR, PD1, PD0. On the 8th bit:
    - latch result: A=CH_X gives x_value, A=CH_Y gives y_value, any other code gives 0.
    - result width: 12 bits if MODE=0; value[11:4] if MODE=1.
    - set penirq_en = ~PD0.
    - go to BUSY.
  - BUSY: on the next dclk fall, busy=1. On the following fall, busy=0, dout = result MSB, go to DATA with remaining count 11 (or 7).
  - DATA: on each fall, shift the next bit onto dout. After the LSB has been presented, the next fall sets dout=0 and returns to IDLE.
  - A start bit is accepted in IDLE immediately, which permits the 16-clock-per-conversion overlap.
- cs_n synchronized high in any state: within one cycle go to IDLE, dout=0, busy=0, bit count cleared. The latched result is kept, but no partial command takes effect.
- Simultaneous synchronized cs_n rise and dclk edge: cs_n wins and the edge is ignored.
- pen_intr_n = ~(pen_down & penirq_en & state==IDLE & busy==0), registered one cycle.
- x_value/y_value are sampled only at the 8th command bit; later changes do not affect a conversion in progress.
- Rises during BUSY/DATA are ignored. Falls in IDLE/CMD do not change dout (held 0).

Decomposition:
- Package touch_adc_pkg:
  - state enum (IDLE, CMD, BUSY, DATA);
  - ctrl-byte field index constants (S=7, A=6:4, MODE=3, SER=2, PD=1:0);
  - result width constants 12 and 8.
- One sub-module: touch_adc_sync_edge, which does the multi-stage synchronizer plus rise/fall pulse generation. It is instantiated for dclk, with plain synchronizer mode for cs_n and din.

Test Plan:
- Reset with cs_n=1 -> dout=0, busy=0, pen_intr_n=1; release reset with pen_down=1 -> pen_intr_n=0 within SYNC_STAGES+2 cycles.
- x_value=12'hA5C, host sends 8'hD0 (X, 12-bit, PD=00) at dclk = clk/16, 16 dclks -> busy high exactly one dclk period after the 8th rise; dout bits 101001011100 on the next 12 falls; pen_intr_n=1 throughout, then 0 after return to IDLE.
- y_value=12'h3F1, command 8'h98 (Y, 8-bit mode) -> 8 data bits 00111111, then dout=0, IDLE.
- Command 8'h91 (Y, PD0=1) with pen_down=1 -> after the conversion pen_intr_n stays 1. A following 8'h90 re-enables it -> pen_intr_n=0.
- cs_n raised after the 4th data bit of an X read -> dout=0, busy=0 within SYNC_STAGES+2 cycles. The next 8'hD0 returns the full 12-bit value from bit 11.
- Leading zeros: din=0 for 3 rises, then 8'hD0; plus an overlapped start bit issued on the fall that presents the LSB -> both conversions return correct values; x_value changed mid-DATA does not alter the current word.
